// File: rtl/temporal_pool.sv
// Non-overlapping temporal pooling of a feature stream into a first-word-fall-through result FIFO.
// Average pooling by default; define TEMPORAL_POOL_MAX_EN to build max pooling instead.
module temporal_pool #(
  parameter int DATA_WIDTH = 16,
  parameter int POOL_SIZE  = 8,
  parameter int OUT_DEPTH  = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic                         x_valid,
  output logic signed [DATA_WIDTH-1:0] y_out,
  output logic                         y_valid,
  input  logic                         y_ready,
  output logic                         overflow,
  output logic [CNT_WIDTH-1:0]         drop_cnt
);

  localparam int SHIFT = $clog2(POOL_SIZE);
  localparam int AW    = $clog2(OUT_DEPTH);

  // ---------------------------------------------------------------------------
  // Window sample counter
  // ---------------------------------------------------------------------------
  logic [SHIFT-1:0]             cnt_q, cnt_d;
  logic                         win_done;
  logic signed [DATA_WIDTH-1:0] result;

  assign win_done = x_valid && (cnt_q == SHIFT'(POOL_SIZE - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (x_valid) begin
      cnt_d = win_done ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef TEMPORAL_POOL_MAX_EN
  // ---------------------------------------------------------------------------
  // Running maximum; the first sample of a window replaces whatever is held
  // ---------------------------------------------------------------------------
  logic signed [DATA_WIDTH-1:0] max_q, max_d, max_nxt;

  always_comb begin
    max_nxt = max_q;
    if ((cnt_q == '0) || (x_in > max_q)) begin
      max_nxt = x_in;
    end
  end

  always_comb begin
    max_d = max_q;
    if (clr) begin
      max_d = '0;
    end else if (x_valid) begin
      max_d = win_done ? '0 : max_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
    end else begin
      max_q <= max_d;
    end
  end

  assign result = max_nxt;
`else
  // ---------------------------------------------------------------------------
  // Sign-extended accumulator; the mean is the top DATA_WIDTH bits of the sum
  // ---------------------------------------------------------------------------
  localparam int ACC_W = DATA_WIDTH + SHIFT;

  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;

  assign acc_sum = acc_q + $signed({{SHIFT{x_in[DATA_WIDTH-1]}}, x_in});

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (x_valid) begin
      acc_d = win_done ? '0 : acc_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Dropping the low SHIFT bits is an arithmetic shift that rounds toward -inf.
  assign result = acc_sum[ACC_W-1:SHIFT];
`endif

  // ---------------------------------------------------------------------------
  // Output FIFO: extra pointer bit separates full from empty
  // ---------------------------------------------------------------------------
  logic [AW:0]                  wr_ptr_q, wr_ptr_d;
  logic [AW:0]                  rd_ptr_q, rd_ptr_d;
  logic signed [DATA_WIDTH-1:0] mem_q [OUT_DEPTH];
  logic                         fifo_empty, fifo_full;
  logic                         pop, push, drop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop on the same edge frees the slot the push lands in.
  assign pop  = !fifo_empty && y_ready;
  assign push = win_done && (!fifo_full || pop);
  assign drop = win_done && fifo_full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= result;
    end
  end

  assign y_valid = !fifo_empty;
  assign y_out   = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // ---------------------------------------------------------------------------
  // Drop accounting
  // ---------------------------------------------------------------------------
  logic                 overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_temporal_pool.sv
// Self-checking bench for temporal_pool with POOL_SIZE=4, OUT_DEPTH=4 and a narrow drop counter.
module tb_temporal_pool;

  localparam int DW = 16;
  localparam int P  = 4;
  localparam int D  = 4;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 clr;
  logic signed [DW-1:0] x_in;
  logic                 x_valid;
  logic signed [DW-1:0] y_out;
  logic                 y_valid;
  logic                 y_ready;
  logic                 overflow;
  logic [CW-1:0]        drop_cnt;

  int checks = 0;
  int errors = 0;

  // Reference state: samples of the open window, expected FIFO contents, drop status.
  int                   win[$];
  logic signed [DW-1:0] exp_q[$];
  bit                   exp_ovf;
  int                   exp_drop;

  always #5 clk = ~clk;

  temporal_pool #(
    .DATA_WIDTH(DW),
    .POOL_SIZE (P),
    .OUT_DEPTH (D),
    .CNT_WIDTH (CW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .x_in    (x_in),
    .x_valid (x_valid),
    .y_out   (y_out),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  function automatic logic signed [DW-1:0] pool_ref();
    int r;
`ifdef TEMPORAL_POOL_MAX_EN
    r = win[0];
    foreach (win[i]) if (win[i] > r) r = win[i];
`else
    int sum;
    sum = 0;
    foreach (win[i]) sum += win[i];
    r = sum / P;
    if ((sum % P != 0) && (sum < 0)) r = r - 1;
`endif
    return DW'(r);
  endfunction

  function automatic logic signed [DW-1:0] exp_head();
    return (exp_q.size() != 0) ? exp_q[0] : '0;
  endfunction

  task automatic model_clear();
    win.delete();
    exp_q.delete();
    exp_ovf  = 1'b0;
    exp_drop = 0;
  endtask

  // Drive one clock cycle and advance the reference model across that edge.
  task automatic step(input bit v, input logic signed [DW-1:0] x, input bit r, input bit c);
    bit                   pop, full, done;
    logic signed [DW-1:0] res;
    x_valid = v;
    x_in    = x;
    y_ready = r;
    clr     = c;
    res     = '0;
    done    = 1'b0;
    pop     = (exp_q.size() != 0) && r;
    full    = (exp_q.size() == D);
    if (c) begin
      model_clear();
    end else begin
      if (v) begin
        win.push_back(int'(x));
        if (win.size() == P) begin
          res = pool_ref();
          win.delete();
          done = 1'b1;
        end
      end
      if (pop) exp_q.delete(0);
      if (done) begin
        if (full && !pop) begin
          exp_ovf = 1'b1;
          if (exp_drop < CMAX) exp_drop++;
        end else begin
          exp_q.push_back(res);
        end
      end
    end
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    y_ready = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    clr     = 1'b0;
    x_valid = 1'b0;
    x_in    = '0;
    y_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid got %0b exp 0", y_valid); end
    checks++; if (y_out !== '0) begin errors++; $display("FAIL reset_y_out got %0d exp 0", y_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
    checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); end
    rst_n = 1'b1;
    step(0, '0, 0, 0);
  endtask

  task automatic test_directed();
    int seqs [4][4];
    int exps [4];
`ifdef TEMPORAL_POOL_MAX_EN
    seqs = '{'{3, -7, 9, 1}, '{-5, -2, -9, -3}, '{32767, 32767, 32767, 32767}, '{-32768, -32768, -32768, -32768}};
    exps = '{9, -2, 32767, -32768};
`else
    seqs = '{'{1, 2, 3, 4}, '{-1, -2, -3, -4}, '{32767, 32767, 32767, 32767}, '{-32768, -32768, -32768, -32768}};
    exps = '{2, -3, 32767, -32768};
`endif
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < P - 1; k++) step(1, DW'(seqs[s][k]), 1, 0);
      checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL directed_early seq %0d y_valid got %0b exp 0", s, y_valid); end
      step(1, DW'(seqs[s][P-1]), 1, 0);
      checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL directed_valid seq %0d got %0b exp 1", s, y_valid); end
      checks++; if (y_out !== DW'(exps[s])) begin errors++; $display("FAIL directed_value seq %0d got %0d exp %0d", s, y_out, exps[s]); end
      step(0, '0, 1, 0);
      checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL directed_one_cycle seq %0d y_valid got %0b exp 0", s, y_valid); end
    end
  endtask

  task automatic test_gapped();
    bit vpat [7];
    int xs [4];
    int n;
    logic signed [DW-1:0] exp_val;
    vpat = '{1, 0, 0, 1, 0, 1, 1};
    xs   = '{4, 8, 12, 16};
`ifdef TEMPORAL_POOL_MAX_EN
    exp_val = 16;
`else
    exp_val = 10;
`endif
    n = 0;
    for (int i = 0; i < 7; i++) begin
      if (vpat[i]) begin
        step(1, DW'(xs[n]), 1, 0);
        n++;
      end else begin
        step(0, DW'($urandom), 1, 0);
      end
      if (i < 6) begin
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL gapped_early cyc %0d y_valid got %0b exp 0", i, y_valid); end
      end
    end
    checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL gapped_valid got %0b exp 1", y_valid); end
    checks++; if (y_out !== exp_val) begin errors++; $display("FAIL gapped_value got %0d exp %0d", y_out, exp_val); end
    step(0, '0, 1, 0);
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL gapped_single y_valid got %0b exp 0", y_valid); end
  endtask

  task automatic test_overflow();
    for (int w = 0; w < 5; w++)
      for (int k = 0; k < P; k++) step(1, DW'($urandom), 0, 0);
    checks++; if (exp_q.size() != D || y_valid !== 1'b1) begin errors++; $display("FAIL ovf_full y_valid got %0b model depth %0d", y_valid, exp_q.size()); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
    checks++; if (drop_cnt !== CW'(1)) begin errors++; $display("FAIL ovf_drop_cnt got %0d exp 1", drop_cnt); end
    for (int w = 0; w < 9; w++)
      for (int k = 0; k < P; k++) step(1, DW'($urandom), 0, 0);
    checks++; if (drop_cnt !== CW'(CMAX)) begin errors++; $display("FAIL ovf_saturate got %0d exp %0d", drop_cnt, CMAX); end
    for (int i = 0; i < D; i++) begin
      checks++; if (y_valid !== 1'b1 || y_out !== exp_head()) begin errors++; $display("FAIL ovf_drain idx %0d got v%0b %0d exp v1 %0d", i, y_valid, y_out, exp_head()); end
      step(0, '0, 1, 0);
    end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained y_valid got %0b exp 0", y_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", overflow); end
  endtask

  task automatic test_reset_mid_window();
    step(1, DW'(1000), 0, 0);
    step(1, DW'(-77), 0, 0);
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++; if (overflow !== 1'b0 || drop_cnt !== '0) begin errors++; $display("FAIL rst_mid_flags got ovf %0b drop %0d exp 0 0", overflow, drop_cnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < P; k++) step(1, DW'(1), 0, 0);
    checks++; if (y_valid !== 1'b1 || y_out !== DW'(1)) begin errors++; $display("FAIL rst_mid_result got v%0b %0d exp v1 1", y_valid, y_out); end
    step(0, '0, 1, 0);
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_single y_valid got %0b exp 0", y_valid); end
    checks++; if (overflow !== 1'b0 || drop_cnt !== '0) begin errors++; $display("FAIL rst_mid_after got ovf %0b drop %0d exp 0 0", overflow, drop_cnt); end
  endtask

  task automatic test_push_pop_full();
    int n;
    step(1, DW'(500), 0, 0);
    step(1, DW'(-500), 0, 0);
    step(0, '0, 0, 1);
    checks++; if (y_valid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== '0) begin errors++; $display("FAIL clr_state got v%0b ovf %0b drop %0d exp 0 0 0", y_valid, overflow, drop_cnt); end
    for (int w = 0; w < D; w++)
      for (int k = 0; k < P; k++) step(1, DW'($urandom), 0, 0);
    for (int k = 0; k < P - 1; k++) step(1, DW'($urandom), 0, 0);
    step(1, DW'($urandom), 1, 0);
    checks++; if (overflow !== 1'b0 || drop_cnt !== '0) begin errors++; $display("FAIL pushpop_nodrop got ovf %0b drop %0d exp 0 0", overflow, drop_cnt); end
    n = 0;
    for (int i = 0; i < 2 * D; i++) begin
      if (y_valid === 1'b1) begin
        checks++; if (y_out !== exp_head()) begin errors++; $display("FAIL pushpop_order idx %0d got %0d exp %0d", n, y_out, exp_head()); end
        n++;
      end
      step(0, '0, 1, 0);
    end
    checks++; if (n != D) begin errors++; $display("FAIL pushpop_occupancy got %0d exp %0d", n, D); end
  endtask

  task automatic test_random();
    bit v, r, c;
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(9) < 7);
      r = ((i / 200) % 2 == 1) ? ($urandom_range(7) == 0) : ($urandom_range(1) == 1);
      c = ($urandom_range(199) == 0);
      step(v, DW'($urandom), r, c);
      checks++; if (y_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rand_valid cyc %0d got %0b exp %0b", i, y_valid, exp_q.size() != 0); end
      checks++; if (y_out !== exp_head()) begin errors++; $display("FAIL rand_y_out cyc %0d got %0d exp %0d", i, y_out, exp_head()); end
      checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL rand_overflow cyc %0d got %0b exp %0b", i, overflow, exp_ovf); end
      checks++; if (drop_cnt !== CW'(exp_drop)) begin errors++; $display("FAIL rand_drop_cnt cyc %0d got %0d exp %0d", i, drop_cnt, exp_drop); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_gapped();
    test_overflow();
    test_reset_mid_window();
    test_push_pop_full();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
